// File: rtl/exu_dp_if.sv
// Shared handler-to-datapath bus: ALU opcode/operands, GPR read/write ports.
package exu_dp_pkg;
    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'h8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'h9;
endpackage

interface exu_dp_if #(
    parameter int XLEN = 32
);
    logic [exu_dp_pkg::ALU_OP_W-1:0] alu_opcode;
    logic [XLEN-1:0]                 alu_src1;
    logic [XLEN-1:0]                 alu_src2;
    logic [XLEN-1:0]                 alu_dst;
    logic [4:0]                      gpr_waddr;
    logic [XLEN-1:0]                 gpr_wdata;
    logic                            gpr_wen;
    logic [4:0]                      gpr_raddr1;
    logic [4:0]                      gpr_raddr2;
    logic [XLEN-1:0]                 gpr_rdata1;
    logic [XLEN-1:0]                 gpr_rdata2;

    modport master (
        output alu_opcode, alu_src1, alu_src2,
        output gpr_waddr, gpr_wdata, gpr_wen, gpr_raddr1, gpr_raddr2,
        input  alu_dst, gpr_rdata1, gpr_rdata2
    );

    modport slave (
        input  alu_opcode, alu_src1, alu_src2,
        input  gpr_waddr, gpr_wdata, gpr_wen, gpr_raddr1, gpr_raddr2,
        output alu_dst, gpr_rdata1, gpr_rdata2
    );
endinterface

// File: rtl/exu_dp.sv
// EXU execution datapath: combinational ALU, integer register file with
// x0 hardwired to zero, and the cycle / retired-instruction counters.
module exu_dp
    import exu_dp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int GPR_NUM = 32,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    exu_dp_if.slave          dp_ctrl,
    input  logic             iexec_req_hsk,
    output logic [CNT_W-1:0] cycle,
    output logic [CNT_W-1:0] instret
);

    logic [XLEN-1:0]  gpr_q [GPR_NUM];
    logic [CNT_W-1:0] cycle_q,   cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [4:0]       shamt;

    assign shamt = dp_ctrl.alu_src2[4:0];

    // ALU result, purely from opcode and operands; unknown opcodes yield 0.
    always_comb begin
        dp_ctrl.alu_dst = '0;
        case (dp_ctrl.alu_opcode)
            ALU_ADD:  dp_ctrl.alu_dst = dp_ctrl.alu_src1 + dp_ctrl.alu_src2;
            ALU_SUB:  dp_ctrl.alu_dst = dp_ctrl.alu_src1 - dp_ctrl.alu_src2;
            ALU_AND:  dp_ctrl.alu_dst = dp_ctrl.alu_src1 & dp_ctrl.alu_src2;
            ALU_OR:   dp_ctrl.alu_dst = dp_ctrl.alu_src1 | dp_ctrl.alu_src2;
            ALU_XOR:  dp_ctrl.alu_dst = dp_ctrl.alu_src1 ^ dp_ctrl.alu_src2;
            ALU_SLT:  dp_ctrl.alu_dst = {{(XLEN-1){1'b0}},
                                         $signed(dp_ctrl.alu_src1) < $signed(dp_ctrl.alu_src2)};
            ALU_SLTU: dp_ctrl.alu_dst = {{(XLEN-1){1'b0}},
                                         dp_ctrl.alu_src1 < dp_ctrl.alu_src2};
            ALU_SLL:  dp_ctrl.alu_dst = dp_ctrl.alu_src1 << shamt;
            ALU_SRL:  dp_ctrl.alu_dst = dp_ctrl.alu_src1 >> shamt;
            ALU_SRA:  dp_ctrl.alu_dst = $signed(dp_ctrl.alu_src1) >>> shamt;
            default:  dp_ctrl.alu_dst = '0;
        endcase
    end

    // Register file write; entry 0 is never written so x0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GPR_NUM; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (dp_ctrl.gpr_wen && (dp_ctrl.gpr_waddr != 5'd0)) begin
            gpr_q[dp_ctrl.gpr_waddr] <= dp_ctrl.gpr_wdata;
        end
    end

    // Read ports are combinational with no bypass: a same-cycle write is
    // seen only after its edge.
    always_comb begin
        dp_ctrl.gpr_rdata1 = '0;
        dp_ctrl.gpr_rdata2 = '0;
        if (dp_ctrl.gpr_raddr1 != 5'd0) dp_ctrl.gpr_rdata1 = gpr_q[dp_ctrl.gpr_raddr1];
        if (dp_ctrl.gpr_raddr2 != 5'd0) dp_ctrl.gpr_rdata2 = gpr_q[dp_ctrl.gpr_raddr2];
    end

    // Counter next values; both wrap silently.
    always_comb begin
        cycle_d   = cycle_q + CNT_W'(1);
        instret_d = instret_q + CNT_W'(iexec_req_hsk);
    end

    // Counter registers, held at zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle   = cycle_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_exu_dp.sv
// Directed bench for exu_dp: ALU vector table plus register-file, reset
// and counter sequences.
module tb_exu_dp;
    import exu_dp_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic             clk;
    logic             rst;
    logic             iexec_req_hsk;
    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] instret;

    int errors = 0;
    int checks = 0;

    exu_dp_if #(.XLEN(XLEN)) dp_if ();

    exu_dp #(.XLEN(XLEN), .GPR_NUM(32), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .dp_ctrl       (dp_if.slave),
        .iexec_req_hsk (iexec_req_hsk),
        .cycle         (cycle),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        string           name;
    } alu_vec_t;

    alu_vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{ALU_ADD,  32'h8000_0000, 32'h0001_2000, 32'h8001_2000, "add"};
        vecs[1]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, "sub"};
        vecs[2]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and"};
        vecs[3]  = '{ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or"};
        vecs[4]  = '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor"};
        vecs[5]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg"};
        vecs[6]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_big"};
        vecs[7]  = '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slt_pos"};
        vecs[8]  = '{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_small"};
        vecs[9]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "sll31"};
        vecs[10] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, "srl_mask"};
        vecs[11] = '{ALU_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra_mask"};
        vecs[12] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap"};
        vecs[13] = '{4'hF,     32'h1234_5678, 32'h0000_0001, 32'h0000_0000, "undef_op"};

        rst                = 1'b1;
        iexec_req_hsk      = 1'b0;
        dp_if.alu_opcode   = '0;
        dp_if.alu_src1     = '0;
        dp_if.alu_src2     = '0;
        dp_if.gpr_waddr    = '0;
        dp_if.gpr_wdata    = '0;
        dp_if.gpr_wen      = 1'b0;
        dp_if.gpr_raddr1   = 5'd5;
        dp_if.gpr_raddr2   = 5'd31;

        // reset state
        tick();
        tick();
        check("rst_cycle",   cycle,   64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_rd1",     {32'd0, dp_if.gpr_rdata1}, 64'd0);
        check("rst_rd2",     {32'd0, dp_if.gpr_rdata2}, 64'd0);
        rst = 1'b0;

        // ALU table
        for (int i = 0; i < 14; i++) begin
            dp_if.alu_opcode = vecs[i].op;
            dp_if.alu_src1   = vecs[i].a;
            dp_if.alu_src2   = vecs[i].b;
            #1;
            check({"alu_", vecs[i].name}, {32'd0, dp_if.alu_dst}, {32'd0, vecs[i].exp});
        end

        // fresh reset so counters are known
        rst = 1'b1;
        #1;
        rst = 1'b0;

        // AUIPC-style add, write and retire in one cycle
        dp_if.alu_opcode = ALU_ADD;
        dp_if.alu_src1   = 32'h8000_0000;
        dp_if.alu_src2   = 32'h0001_2000;
        #1;
        check("auipc_dst", {32'd0, dp_if.alu_dst}, 64'h8001_2000);
        dp_if.gpr_wen    = 1'b1;
        dp_if.gpr_waddr  = 5'd5;
        dp_if.gpr_wdata  = dp_if.alu_dst;
        iexec_req_hsk    = 1'b1;
        dp_if.gpr_raddr1 = 5'd5;
        #1;
        check("auipc_pre_write", {32'd0, dp_if.gpr_rdata1}, 64'd0);
        tick();
        dp_if.gpr_wen = 1'b0;
        iexec_req_hsk = 1'b0;
        #1;
        check("auipc_rd",      {32'd0, dp_if.gpr_rdata1}, 64'h8001_2000);
        check("auipc_instret", instret, 64'd1);
        check("auipc_cycle",   cycle,   64'd1);

        // x0 protection
        dp_if.gpr_wen    = 1'b1;
        dp_if.gpr_waddr  = 5'd0;
        dp_if.gpr_wdata  = 32'hDEAD_BEEF;
        tick();
        dp_if.gpr_wen    = 1'b0;
        dp_if.gpr_raddr1 = 5'd0;
        dp_if.gpr_raddr2 = 5'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("x0_rd1", {32'd0, dp_if.gpr_rdata1}, 64'd0);
            check("x0_rd2", {32'd0, dp_if.gpr_rdata2}, 64'd0);
            tick();
        end

        // read-during-write returns the old value
        dp_if.gpr_wen   = 1'b1;
        dp_if.gpr_waddr = 5'd7;
        dp_if.gpr_wdata = 32'h11;
        tick();
        dp_if.gpr_wdata  = 32'h22;
        dp_if.gpr_raddr1 = 5'd7;
        dp_if.gpr_raddr2 = 5'd5;
        #1;
        check("rdw_old", {32'd0, dp_if.gpr_rdata1}, 64'h11);
        check("rd2_x5",  {32'd0, dp_if.gpr_rdata2}, 64'h8001_2000);
        tick();
        dp_if.gpr_wen = 1'b0;
        #1;
        check("rdw_new", {32'd0, dp_if.gpr_rdata1}, 64'h22);

        // mid-run reset: 10 cycles, 4 handshakes, then async clear
        rst = 1'b1;
        #1;
        rst = 1'b0;
        dp_if.gpr_wen   = 1'b1;
        dp_if.gpr_waddr = 5'd3;
        dp_if.gpr_wdata = 32'h55;
        for (int i = 0; i < 10; i++) begin
            iexec_req_hsk = (i == 0 || i == 3 || i == 4 || i == 8);
            tick();
            dp_if.gpr_wen = 1'b0;
        end
        iexec_req_hsk    = 1'b0;
        dp_if.gpr_raddr1 = 5'd3;
        #1;
        check("run_cycle",   cycle,   64'd10);
        check("run_instret", instret, 64'd4);
        check("run_x3",      {32'd0, dp_if.gpr_rdata1}, 64'h55);
        rst = 1'b1;
        #1;
        check("arst_x3",      {32'd0, dp_if.gpr_rdata1}, 64'd0);
        check("arst_cycle",   cycle,   64'd0);
        check("arst_instret", instret, 64'd0);
        dp_if.gpr_wen   = 1'b1;
        dp_if.gpr_waddr = 5'd3;
        dp_if.gpr_wdata = 32'hAA;
        iexec_req_hsk   = 1'b1;
        tick();
        check("rst_wen_x3",  {32'd0, dp_if.gpr_rdata1}, 64'd0);
        check("rst_hold_cy", cycle,   64'd0);
        check("rst_hold_ir", instret, 64'd0);
        dp_if.gpr_wen = 1'b0;
        iexec_req_hsk = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_cycle",   cycle,   64'd1);
        check("post_rst_instret", instret, 64'd0);
        check("post_rst_x3",      {32'd0, dp_if.gpr_rdata1}, 64'd0);

        // instret wrap
        force dut.instret_q = '1;
        #1;
        check("wrap_forced", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        release dut.instret_q;
        iexec_req_hsk = 1'b1;
        tick();
        iexec_req_hsk = 1'b0;
        #1;
        check("wrap_instret", instret, 64'd0);
        check("wrap_cycle",   cycle,   64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
